// File: rtl/sw_rxbuf_len_ctrl_if.sv
// Bundle of the RX length-control handshakes (NEWLEN in, RELLEN out, DMA request/completion).
// slave : the length controller (accepts NEWLEN, drives RDY/RELLEN/REQ/ERR, takes ACK/DONE).
// master: the surrounding environment (buffer top + DMA engine).
interface sw_rxbuf_len_ctrl_if #(
  parameter int FLOWS     = 2,
  parameter int LEN_WIDTH = 16,
  parameter int FLOW_W    = $clog2(FLOWS)
);
  logic [FLOWS*LEN_WIDTH-1:0] rx_newlen;
  logic [FLOWS-1:0]           rx_newlen_dv;
  logic [FLOWS-1:0]           rx_newlen_rdy;
  logic [FLOWS*LEN_WIDTH-1:0] rx_rellen;
  logic [FLOWS-1:0]           rx_rellen_dv;
  logic                       req_vld;
  logic [FLOW_W-1:0]          req_flow;
  logic [LEN_WIDTH-1:0]       req_len;
  logic                       req_ack;
  logic                       done_vld;
  logic [FLOW_W-1:0]          done_flow;
  logic [LEN_WIDTH-1:0]       done_len;
  logic                       err;

  modport slave (
    input  rx_newlen, rx_newlen_dv, req_ack, done_vld, done_flow, done_len,
    output rx_newlen_rdy, rx_rellen, rx_rellen_dv, req_vld, req_flow, req_len, err
  );

  modport master (
    output rx_newlen, rx_newlen_dv, req_ack, done_vld, done_flow, done_len,
    input  rx_newlen_rdy, rx_rellen, rx_rellen_dv, req_vld, req_flow, req_len, err
  );
endinterface

// File: rtl/sw_rxbuf_len_ctrl.sv
// Purpose : accumulates per-flow pending RX bytes, issues round-robin bounded DMA requests,
//           returns DMA completions as RELLEN releases; sticky ERR on over-completion.
// Latency : NEWLEN accepted at t -> REQ_VLD at t+2; DONE at t -> RELLEN_DV pulse at t+1.
// Backpr. : RDY[i] drops while pending[i] has its top bit set; REQ holds stable until ACK.
// Ports   : clk, reset (sync, active-high), bus (slave modport of sw_rxbuf_len_ctrl_if).
module sw_rxbuf_len_ctrl #(
  parameter int FLOWS     = 2,
  parameter int LEN_WIDTH = 16,
  parameter int MAX_REQ   = 4096
) (
  input logic                 clk,
  input logic                 reset,
  sw_rxbuf_len_ctrl_if.slave  bus
);
  localparam int CNT_WIDTH = LEN_WIDTH + 1;
  localparam int FLOW_W    = $clog2(FLOWS);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   pending   [FLOWS];
  logic [CNT_WIDTH-1:0]   inflight  [FLOWS];
  logic [CNT_WIDTH-1:0]   pend_nxt  [FLOWS];
  logic [CNT_WIDTH-1:0]   infl_nxt  [FLOWS];
  logic [FLOW_W-1:0]      rr_ptr, rr_ptr_nxt;
  logic [FLOW_W-1:0]      req_flow, req_flow_nxt;
  logic [LEN_WIDTH-1:0]   req_len, req_len_nxt;
  logic [FLOWS*LEN_WIDTH-1:0] rellen;
  logic [FLOWS-1:0]       rellen_dv;
  logic                   err;

  logic                   hit;
  logic [FLOW_W-1:0]      hit_flow;
  logic [FLOW_W-1:0]      idx;
  logic                   ack_fire;
  logic [CNT_WIDTH-1:0]   infl_sel;
  logic                   over;
  logic [LEN_WIDTH-1:0]   rel;

  assign ack_fire = (state == REQ) && bus.req_ack;

  assign bus.req_vld      = (state == REQ);
  assign bus.req_flow     = req_flow;
  assign bus.req_len      = req_len;
  assign bus.rx_rellen    = rellen;
  assign bus.rx_rellen_dv = rellen_dv;
  assign bus.err          = err;

  for (genvar g = 0; g < FLOWS; g++) begin : g_rdy
    assign bus.rx_newlen_rdy[g] = ~pending[g][CNT_WIDTH-1];
  end

  // Round-robin search: walk downward so the smallest offset from rr_ptr wins.
  // The index add wraps naturally because FLOWS is a power of two.
  always_comb begin
    hit      = 1'b0;
    hit_flow = rr_ptr;
    idx      = rr_ptr;
    for (int k = FLOWS - 1; k >= 0; k--) begin
      idx = rr_ptr + FLOW_W'(k);
      if (pending[idx] != '0) begin
        hit      = 1'b1;
        hit_flow = idx;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    req_flow_nxt = req_flow;
    req_len_nxt  = req_len;
    case (state)
      IDLE: begin
        if (hit) begin
          state_nxt    = REQ;
          req_flow_nxt = hit_flow;
          req_len_nxt  = (pending[hit_flow] > CNT_WIDTH'(MAX_REQ)) ? LEN_WIDTH'(MAX_REQ)
                                                                  : pending[hit_flow][LEN_WIDTH-1:0];
        end
      end
      REQ: begin
        if (bus.req_ack) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = req_flow + FLOW_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Completion clamp uses the pre-update inflight value; when over-completing,
  // rel equals the old inflight (which is then below DONE_LEN, so it fits LEN_WIDTH).
  assign infl_sel = inflight[bus.done_flow];
  assign over     = CNT_WIDTH'(bus.done_len) > infl_sel;
  assign rel      = over ? infl_sel[LEN_WIDTH-1:0] : bus.done_len;

  always_comb begin
    for (int i = 0; i < FLOWS; i++) begin
      pend_nxt[i] = pending[i];
      infl_nxt[i] = inflight[i];
      if (bus.rx_newlen_dv[i] && !pending[i][CNT_WIDTH-1])
        pend_nxt[i] = pend_nxt[i] + CNT_WIDTH'(bus.rx_newlen[i*LEN_WIDTH +: LEN_WIDTH]);
      if (ack_fire && (req_flow == FLOW_W'(i))) begin
        pend_nxt[i] = pend_nxt[i] - CNT_WIDTH'(req_len);
        infl_nxt[i] = infl_nxt[i] + CNT_WIDTH'(req_len);
      end
      if (bus.done_vld && (bus.done_flow == FLOW_W'(i)))
        infl_nxt[i] = infl_nxt[i] - CNT_WIDTH'(rel);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      req_flow  <= '0;
      req_len   <= '0;
      rellen    <= '0;
      rellen_dv <= '0;
      err       <= 1'b0;
      for (int i = 0; i < FLOWS; i++) begin
        pending[i]  <= '0;
        inflight[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      req_flow  <= req_flow_nxt;
      req_len   <= req_len_nxt;
      rellen    <= '0;
      rellen_dv <= '0;
      for (int i = 0; i < FLOWS; i++) begin
        pending[i]  <= pend_nxt[i];
        inflight[i] <= infl_nxt[i];
      end
      if (bus.done_vld) begin
        rellen_dv[bus.done_flow]                         <= 1'b1;
        rellen[bus.done_flow*LEN_WIDTH +: LEN_WIDTH]     <= rel;
        if (over) err <= 1'b1;
      end
    end
  end
endmodule
